// File: rtl/clock_datapath_pkg.sv
// rtl/clock_datapath_pkg.sv - field ranges and widths shared by the time-of-day datapath
package clock_datapath_pkg;

  localparam int MSEC_MAX = 99;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  localparam int MSEC_W = 7;
  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;

endpackage

// File: rtl/clock_datapath_time_field_counter.sv
// rtl/clock_datapath_time_field_counter.sv - modulo-(MAX+1) field with natural carry and manual adjust
module time_field_counter #(
  parameter int MAX   = 59,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_adj,
  output logic [WIDTH-1:0] o_val,
  output logic             o_carry
);

  localparam logic [WIDTH:0] LP_MAX = (WIDTH+1)'(MAX);
  localparam logic [WIDTH:0] LP_MOD = (WIDTH+1)'(MAX + 1);

  logic [WIDTH-1:0] r_val;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_wrapped;
  logic [WIDTH-1:0] w_next;

  // Sum never exceeds MAX+2 because r_val <= MAX, so one subtraction wraps it.
  always_comb begin
    w_sum     = {1'b0, r_val} + {{WIDTH{1'b0}}, i_inc} + {{WIDTH{1'b0}}, i_adj};
    w_wrapped = w_sum - LP_MOD;
    w_next    = r_val;
    if (w_sum > LP_MAX) begin
      w_next = w_wrapped[WIDTH-1:0];
    end else begin
      w_next = w_sum[WIDTH-1:0];
    end
  end

  // Only the natural increment crossing MAX carries; adjust wraps stay local.
  assign o_carry = i_inc & (r_val == LP_MAX[WIDTH-1:0]);
  assign o_val   = r_val;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_val <= '0;
    end else begin
      r_val <= w_next;
    end
  end

endmodule

// File: rtl/clock_datapath.sv
// rtl/clock_datapath.sv - 100 Hz tick divider feeding the centisecond..hour field chain
module clock_datapath
  import clock_datapath_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int TICK_HZ  = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_adj_sec,
  input  logic              i_adj_min,
  input  logic              i_adj_hour,
  output logic [MSEC_W-1:0] o_msec,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic              o_tick
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int CNT_W = $clog2(DIV);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] LP_PRE  = CNT_W'(DIV - 2);

  logic [CNT_W-1:0] r_div_cnt;
  logic             r_tick;
  logic             w_carry_sec;
  logic             w_carry_min;
  logic             w_carry_hour;

  // r_tick is set one edge early so it is high exactly while the counter sits at DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      if (r_div_cnt == LP_LAST) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + CNT_W'(1);
      end
      r_tick <= (r_div_cnt == LP_PRE);
    end
  end

  assign o_tick = r_tick;

  time_field_counter #(.MAX(MSEC_MAX), .WIDTH(MSEC_W)) u_msec (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (r_tick),
    .i_adj   (1'b0),
    .o_val   (o_msec),
    .o_carry (w_carry_sec)
  );

  time_field_counter #(.MAX(SEC_MAX), .WIDTH(SEC_W)) u_sec (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_carry_sec),
    .i_adj   (i_adj_sec),
    .o_val   (o_sec),
    .o_carry (w_carry_min)
  );

  time_field_counter #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_carry_min),
    .i_adj   (i_adj_min),
    .o_val   (o_min),
    .o_carry (w_carry_hour)
  );

  time_field_counter #(.MAX(HOUR_MAX), .WIDTH(HOUR_W)) u_hour (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_carry_hour),
    .i_adj   (i_adj_hour),
    .o_val   (o_hour),
    .o_carry ()
  );

endmodule

// File: tb/tb_clock_datapath.sv
// tb/tb_clock_datapath.sv - directed self-checking bench for clock_datapath at DIV=10
module tb_clock_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_adj_sec  = 1'b0;
  logic       i_adj_min  = 1'b0;
  logic       i_adj_hour = 1'b0;
  logic [6:0] o_msec;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hour;
  logic       o_tick;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clock_datapath #(.CLK_FREQ(1000), .TICK_HZ(100)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .i_adj_sec  (i_adj_sec),
    .i_adj_min  (i_adj_min),
    .i_adj_hour (i_adj_hour),
    .o_msec     (o_msec),
    .o_sec      (o_sec),
    .o_min      (o_min),
    .o_hour     (o_hour),
    .o_tick     (o_tick)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s, input int cs);
    check_eq({tag, ".hour"}, 32'(o_hour), 32'(h));
    check_eq({tag, ".min"},  32'(o_min),  32'(m));
    check_eq({tag, ".sec"},  32'(o_sec),  32'(s));
    check_eq({tag, ".msec"}, 32'(o_msec), 32'(cs));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Adjust pulses never carry, so h/m/s are dialled in first, then msec runs up to cs.
  // Returns at the negedge right after the tick edge that made msec == cs (divider at 0).
  task automatic set_time(input int h, input int m, input int s, input int cs);
    int n;
    do_reset();
    n = (h > m) ? h : m;
    n = (n > s) ? n : s;
    for (int i = 0; i < n; i++) begin
      i_adj_hour = (i < h);
      i_adj_min  = (i < m);
      i_adj_sec  = (i < s);
      @(negedge clk);
    end
    i_adj_hour = 1'b0;
    i_adj_min  = 1'b0;
    i_adj_sec  = 1'b0;
    for (int k = 0; k < 1200; k++) begin
      if (32'(o_msec) == 32'(cs)) break;
      @(negedge clk);
    end
    check_eq("set_time.msec", 32'(o_msec), 32'(cs));
  endtask

  task automatic wait_tick(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (o_tick) break;
      @(negedge clk);
    end
    check_eq({tag, ".tick"}, 32'(o_tick), 32'd1);
  endtask

  initial begin
    int first_tick;

    // Reset state
    repeat (2) @(negedge clk);
    check_time("reset", 0, 0, 0, 0);
    check_eq("reset.tick", 32'(o_tick), 32'd0);

    // Tick cadence: cycle k is the interval before the k-th edge after release
    rst = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      #1;
      check_eq($sformatf("tick.c%0d", k), 32'(o_tick), (k == 10 || k == 20) ? 32'd1 : 32'd0);
      if (k == 11) check_eq("tick.msec_c11", 32'(o_msec), 32'd1);
      if (k == 21) check_eq("tick.msec_c21", 32'(o_msec), 32'd2);
      @(negedge clk);
    end
    check_time("tick.end", 0, 0, 0, 2);

    // Full-day rollover on one edge
    set_time(23, 59, 59, 99);
    check_time("roll.pre", 23, 59, 59, 99);
    wait_tick("roll");
    @(negedge clk);
    check_time("roll", 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    check_time("roll.post", 0, 0, 0, 1);

    // Adjust wraps without carrying
    set_time(0, 5, 59, 50);
    i_adj_sec = 1'b1;
    @(negedge clk);
    i_adj_sec = 1'b0;
    check_time("adj_sec_wrap", 0, 5, 0, 50);

    set_time(3, 59, 0, 50);
    i_adj_min = 1'b1;
    @(negedge clk);
    i_adj_min = 1'b0;
    check_time("adj_min_wrap", 3, 0, 0, 50);

    set_time(23, 0, 0, 50);
    i_adj_hour = 1'b1;
    @(negedge clk);
    i_adj_hour = 1'b0;
    check_time("adj_hour_wrap", 0, 0, 0, 50);

    // Natural carry and adjust on the same edge
    set_time(0, 7, 59, 99);
    wait_tick("carry_adj59");
    i_adj_sec = 1'b1;
    @(negedge clk);
    i_adj_sec = 1'b0;
    check_time("carry_adj59", 0, 8, 1, 0);

    set_time(0, 7, 58, 99);
    wait_tick("carry_adj58");
    i_adj_sec = 1'b1;
    @(negedge clk);
    i_adj_sec = 1'b0;
    check_time("carry_adj58", 0, 7, 0, 0);

    // All three adjusts together
    do_reset();
    i_adj_sec  = 1'b1;
    i_adj_min  = 1'b1;
    i_adj_hour = 1'b1;
    @(negedge clk);
    i_adj_sec  = 1'b0;
    i_adj_min  = 1'b0;
    i_adj_hour = 1'b0;
    check_time("all_adj", 1, 1, 1, 0);

    // Asynchronous reset between edges
    set_time(12, 34, 56, 78);
    check_time("async.pre", 12, 34, 56, 78);
    #2;
    rst = 1'b1;
    #1;
    check_time("async", 0, 0, 0, 0);
    check_eq("async.tick", 32'(o_tick), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    first_tick = 0;
    for (int k = 1; k <= 15; k++) begin
      #1;
      if (o_tick && first_tick == 0) first_tick = k;
      @(negedge clk);
    end
    check_eq("async.first_tick_cycle", 32'(first_tick), 32'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/clock_datapath.md
Name: clock_datapath

Overview:
- Time-of-day counter datapath that sits directly downstream of the clock control unit.
- Divides the system clock to a 100 Hz tick and keeps centisecond, second, minute and hour fields.
- Applies single-cycle manual-adjust pulses (sec/min/hour) from the control unit.
- Outputs feed the FND/display formatter and the UART time-report path.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- TICK_HZ, 100, centisecond tick rate in Hz; DIV = CLK_FREQ/TICK_HZ, must be an integer ≥ 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- i_adj_sec  input  1  one-cycle pulse, +1 second (manual adjust).
- i_adj_min  input  1  one-cycle pulse, +1 minute.
- i_adj_hour  input  1  one-cycle pulse, +1 hour.
- o_msec  output  7  centiseconds, 0..99.
- o_sec  output  6  seconds, 0..59.
- o_min  output  6  minutes, 0..59.
- o_hour  output  5  hours, 0..23.
- o_tick  output  1  registered 100 Hz strobe, high one cycle per period.

Behaviour:

Reset:
- rst high clears divider, o_tick and all fields to 0 immediately (asynchronous).
- Release is synchronous to the next clk edge.
- Reset mid-count or mid-adjust discards all progress; no pending adjust survives.

Tick divider:
- Counter runs 0..DIV-1 and wraps to 0.
- o_tick = 1 in the cycle the counter equals DIV-1, otherwise 0.
- First tick occurs DIV cycles after reset release.

Centisecond field:
- Increments on the clk edge at which o_tick is high; visible the following cycle.
- 99 + tick → 0 and produces carry_sec in the same cycle (combinational carry).

Field chain:
- sec, min and hour each increment on the incoming carry from the field below.
- sec 59→0 carries to min; min 59→0 carries to hour; hour 23→0 has no carry out.
- A full 23:59:59.99 rollover completes on a single edge.

Manual adjust:
- An adjust pulse sampled high at an edge adds +1 to its field on that edge; 1-cycle latency.
- The field wraps modulo its range (60/60/24).
- An adjust-induced wrap generates no carry; the upper fields are untouched.
- The divider and centiseconds are not reset by adjust.

Simultaneous events:
- Natural carry and adjust on the same field in the same cycle: next value = (value + 2) mod N.
- Carry out is generated only when the natural increment alone wraps (value == N-1 with carry in).
- Example: sec=59 with carry and adjust → sec=1, min+1.
- Example: sec=58 with carry and adjust → sec=0, no carry.
- Multiple adjust inputs high together each apply to their own field independently.

General:
- Adjust pulse width is assumed 1 cycle. A held-high input increments every cycle; this is the upstream block's responsibility.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package: field maxima SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, MSEC_MAX=99, and field widths 7/6/6/5.
- Sub-module time_field_counter (params MAX, WIDTH):
  - inputs clk, rst, i_inc (natural), i_adj;
  - outputs o_val, o_carry;
  - instanced four times (msec with i_adj tied 0).
- Tick divider stays inline in clock_datapath.

Test Plan (CLK_FREQ=1000, TICK_HZ=100, so DIV=10):
- Reset/tick: release rst and run 25 cycles → o_tick high exactly at cycles 10 and 20; o_msec=2 after cycle 21; all other fields 0.
- Full rollover: force state to 23:59:59.99, run to the next tick → next cycle all fields 0, no spurious carries.
- Adjust wrap, no carry: sec=59, pulse i_adj_sec between ticks → sec=0 next cycle, min unchanged.
  - Repeat for min=59 (hour unchanged).
  - Repeat for hour=23 → 0.
- Simultaneous carry+adjust: sec=59, msec=99, i_adj_sec coincident with tick → sec=1, min+1, msec=0.
  - Repeat with sec=58 → sec=0, min unchanged.
- Concurrent adjusts: i_adj_sec, i_adj_min and i_adj_hour high together for 1 cycle from 00:00:00 → 01:01:01 next cycle.
- Async reset mid-operation: assert rst between clk edges at 12:34:56.78 → all outputs 0 before the next edge; first o_tick 10 cycles after release.
